lc3_control_seq: RTL and testbench
==================================

Name: lc3_control_seq

Overview:
- Microsequencer FSM for the LC-3 datapath: drives fetch, decode and execute for a supported opcode subset.
- Produces the per-cycle control word: register loads, bus gates, mux selects and memory strobes.
- Sits directly upstream of the condition-code and branch-enable logic.
  - Issues LD_CC when the NZP flags must capture the bus.
  - Issues LD_BEN at decode.
  - Consumes the registered BEN one cycle later in the BR state.

Parameters:
MEM_TIMEOUT, 16, memory wait-cycle limit before FAULT (used only when SEQ_MEM_WDT_EN is defined; legal range 2..255).

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
IR  in  16  instruction register contents
BEN  in  1  registered branch-enable from the branch comparator
R  in  1  memory ready; read data valid this cycle
LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC  out  1 each  register load enables
GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX  out  1 each  bus drivers; at most one high per cycle
PCMUX  out  2  00 = PC+1, 01 = BUS, 10 = address adder
ADDR1MUX  out  1  0 = PC, 1 = BaseR (IR[8:6])
ADDR2MUX  out  2  00 = zero, 10 = SEXT(IR[8:0])
ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA
MIO_EN  out  1  memory access strobe (read only in this block)
STATE  out  6  current state encoding
FAULT  out  1  sticky fault flag

Behaviour:

State encodings (LC-3 numbering):
- RST = 63, S18 fetch, S33 mem read, S35 load IR, S32 decode.
- S1 ADD, S5 AND, S9 NOT, S0 BR, S22 BR taken, S12 JMP.
- S2 LD address, S25 LD read, S27 LD writeback.
- FLT = 62.

Reset:
- While RST_N = 0: state = RST, FAULT = 0, and every LD_*, GATE_* and MIO_EN output = 0. All selects = 0.
- RST is held one cycle after release, then the FSM moves to S18.

Output model:
- Outputs are decoded from the registered state (Moore).
- The only exception is LD_MDR, which equals R in S33 and S25.

State actions and transitions:
- S18: GATE_PC, LD_MAR, LD_PC, PCMUX = 00. Next: S33.
- S33: MIO_EN = 1, LD_MDR = R. Stay while R = 0; go to S35 on R = 1.
- S35: GATE_MDR, LD_IR. Next: S32.
- S32: LD_BEN. Dispatch on IR[15:12]:
  - 0001 -> S1, 0101 -> S5, 1001 -> S9
  - 0000 -> S0, 1100 -> S12, 0010 -> S2
  - any other opcode -> FLT
- S1 / S5 / S9: GATE_ALU, LD_REG, LD_CC, ALUK = 00 / 01 / 10 respectively. Next: S18.
- S0: no loads. Next: S22 if BEN = 1, else S18.
  - BEN here is the value captured at the S32 edge; the FSM never samples BEN in any other state.
- S22: LD_PC, PCMUX = 10, ADDR1MUX = 0, ADDR2MUX = 10. Next: S18.
- S12: LD_PC, PCMUX = 10, ADDR1MUX = 1, ADDR2MUX = 00. Next: S18.
- S2: GATE_MARMUX, LD_MAR, ADDR1MUX = 0, ADDR2MUX = 10. Next: S25.
- S25: same wait rule as S33. Exit to S27.
- S27: GATE_MDR, LD_REG, LD_CC. Next: S18.
- FLT: all LD_*, GATE_* and MIO_EN outputs = 0; FAULT = 1. Exit only via RST_N.

Timing and latency:
- One instruction takes 4 cycles of fetch/decode plus 1 execute cycle (ALU ops).
- JMP and untaken BR also take 1 execute cycle.
- Taken BR takes 2 execute cycles; LD takes 3 plus memory wait cycles.
- LD_CC is asserted only in S1, S5, S9 and S27. Because the NZP flags are captured on the bus value, the bus must carry the written result in those states.

Boundary conditions:
- R asserted on the first cycle of S33/S25 gives zero wait cycles.
- R held high continuously is legal.
- A reset assertion mid-wait aborts immediately and returns to RST; no partial load is performed.
- When IR changes outside S32 the FSM ignores it.

Optional Feature:
SEQ_MEM_WDT_EN:
- When defined: a cycle counter of width $clog2(MEM_TIMEOUT+1) is added.
  - It is cleared on entry to S33 or S25 and increments each cycle R = 0.
  - If it reaches MEM_TIMEOUT with R still 0, the next state is FLT.
  - R = 1 on the same cycle as expiry wins, and the FSM proceeds normally.
- When undefined: there is no counter, and memory waits are unbounded.

Test Plan:
1. Reset/fetch: release RST_N, R tied 1 -> STATE sequence 63, 18, 33, 35, 32. LD_MAR = LD_PC = 1 only in state 18; all outputs 0 during reset.
2. ADD: IR = 0x1042, R = 1 -> after state 32, STATE = 1 with GATE_ALU = LD_REG = LD_CC = 1 and ALUK = 00, then STATE = 18.
3. BR: IR = 0x0E05 with BEN = 1 -> states 0, 22, 18 with LD_PC = 1, PCMUX = 10 in state 22. With BEN = 0 -> states 0, 18 and no LD_PC.
4. LD with waits: IR = 0x2203, R low for 3 cycles in state 25 -> STATE stays 25 for 4 cycles with LD_MDR rising only with R, then 27 with LD_CC = 1, then 18.
5. Illegal opcode: IR = 0xD000 -> state 32 then 62, FAULT = 1, held for 20 cycles. Asserting RST_N = 0 clears FAULT and gives STATE = 63.
6. Watchdog (SEQ_MEM_WDT_EN defined, MEM_TIMEOUT = 4): R held 0 in state 33 -> state 62 after 4 wait cycles. R = 1 on the 4th wait cycle -> state 35 instead.

Source files
------------

// File: rtl/lc3_control_seq.sv
// LC-3 microsequencer: fetch/decode/execute FSM for ADD, AND, NOT, BR, JMP and LD.
// Optional memory-wait watchdog is enabled by defining SEQ_MEM_WDT_EN.
module lc3_control_seq #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] IR,
    input  logic        BEN,
    input  logic        R,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_REG,
    output logic        LD_CC,
    output logic        LD_PC,
    output logic        GATE_PC,
    output logic        GATE_MDR,
    output logic        GATE_ALU,
    output logic        GATE_MARMUX,
    output logic [1:0]  PCMUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic [5:0]  STATE,
    output logic        FAULT
);

    // state | meaning
    // RST   | reset hold, one cycle after release
    // S18   | fetch: MAR <- PC, PC <- PC+1
    // S33   | fetch memory read, wait for R
    // S35   | IR <- MDR
    // S32   | decode, load BEN, dispatch on opcode
    // S1    | ADD
    // S5    | AND
    // S9    | NOT
    // S0    | BR test on registered BEN
    // S22   | BR taken: PC <- PC + SEXT(off9)
    // S12   | JMP: PC <- BaseR
    // S2    | LD: MAR <- PC + SEXT(off9)
    // S25   | LD memory read, wait for R
    // S27   | LD writeback to register file
    // FLT   | sticky fault, left only through reset
    typedef enum logic [5:0] {
        S0  = 6'd0,
        S1  = 6'd1,
        S2  = 6'd2,
        S5  = 6'd5,
        S9  = 6'd9,
        S12 = 6'd12,
        S18 = 6'd18,
        S22 = 6'd22,
        S25 = 6'd25,
        S27 = 6'd27,
        S32 = 6'd32,
        S33 = 6'd33,
        S35 = 6'd35,
        FLT = 6'd62,
        RST = 6'd63
    } state_t;

    state_t state;
    state_t next_state;
    logic   in_wait;
    logic   wdt_expire;

    assign in_wait = (state == S33) || (state == S25);

`ifdef SEQ_MEM_WDT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WDT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    // Counter idles at zero outside the wait states, so it is clear on entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= '0;
        end else if (in_wait && !R) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign wdt_expire = in_wait && !R && (wait_cnt == WDT_LAST);
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(MEM_TIMEOUT);
    assign wdt_expire     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        LD_MAR      = 1'b0;
        LD_MDR      = 1'b0;
        LD_IR       = 1'b0;
        LD_BEN      = 1'b0;
        LD_REG      = 1'b0;
        LD_CC       = 1'b0;
        LD_PC       = 1'b0;
        GATE_PC     = 1'b0;
        GATE_MDR    = 1'b0;
        GATE_ALU    = 1'b0;
        GATE_MARMUX = 1'b0;
        PCMUX       = 2'b00;
        ADDR1MUX    = 1'b0;
        ADDR2MUX    = 2'b00;
        ALUK        = 2'b00;
        MIO_EN      = 1'b0;
        FAULT       = 1'b0;

        unique case (state)
            RST: begin
                next_state = S18;
            end
            S18: begin
                GATE_PC    = 1'b1;
                LD_MAR     = 1'b1;
                LD_PC      = 1'b1;
                PCMUX      = 2'b00;
                next_state = S33;
            end
            S33: begin
                MIO_EN = 1'b1;
                LD_MDR = R;
                if (R) begin
                    next_state = S35;
                end else if (wdt_expire) begin
                    next_state = FLT;
                end
            end
            S35: begin
                GATE_MDR   = 1'b1;
                LD_IR      = 1'b1;
                next_state = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                case (IR[15:12])
                    4'b0001: next_state = S1;
                    4'b0101: next_state = S5;
                    4'b1001: next_state = S9;
                    4'b0000: next_state = S0;
                    4'b1100: next_state = S12;
                    4'b0010: next_state = S2;
                    default: next_state = FLT;
                endcase
            end
            S1, S5, S9: begin
                GATE_ALU   = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                ALUK       = (state == S1) ? 2'b00 :
                             (state == S5) ? 2'b01 : 2'b10;
                next_state = S18;
            end
            S0: begin
                next_state = BEN ? S22 : S18;
            end
            S22: begin
                LD_PC      = 1'b1;
                PCMUX      = 2'b10;
                ADDR1MUX   = 1'b0;
                ADDR2MUX   = 2'b10;
                next_state = S18;
            end
            S12: begin
                LD_PC      = 1'b1;
                PCMUX      = 2'b10;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b00;
                next_state = S18;
            end
            S2: begin
                GATE_MARMUX = 1'b1;
                LD_MAR      = 1'b1;
                ADDR1MUX    = 1'b0;
                ADDR2MUX    = 2'b10;
                next_state  = S25;
            end
            S25: begin
                MIO_EN = 1'b1;
                LD_MDR = R;
                if (R) begin
                    next_state = S27;
                end else if (wdt_expire) begin
                    next_state = FLT;
                end
            end
            S27: begin
                GATE_MDR   = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S18;
            end
            FLT: begin
                FAULT      = 1'b1;
                next_state = FLT;
            end
            default: begin
                next_state = FLT;
            end
        endcase
    end

    assign STATE = state;

endmodule

// File: tb/tb_lc3_control_seq.sv
// Self-checking bench for lc3_control_seq: per-cycle vector table with a scoreboard
// queue, plus a hand-written bounded fetch/dispatch sequence.
module tb_lc3_control_seq;

    localparam int unsigned TIMEOUT = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic        BEN = 1'b0;
    logic        R = 1'b1;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
    logic        GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, MIO_EN, FAULT;
    logic [5:0]  STATE;

    lc3_control_seq #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N), .IR(IR), .BEN(BEN), .R(R),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_PC(LD_PC),
        .GATE_PC(GATE_PC), .GATE_MDR(GATE_MDR), .GATE_ALU(GATE_ALU),
        .GATE_MARMUX(GATE_MARMUX), .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
        .STATE(STATE), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic [15:0] ir;
        logic        ben;
        logic        r;
        logic [5:0]  st;
    } vec_t;

    typedef struct {
        int          idx;
        logic [5:0]  st;
        logic [19:0] ctl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [19:0] act_ctl;
    assign act_ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
                      GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX,
                      PCMUX, ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, FAULT};

    // Control word expected in each state, written from the state action list.
    function automatic logic [19:0] exp_ctl(input logic [5:0] st, input logic r);
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic g_pc, g_mdr, g_alu, g_mm, a1, mio, flt;
        logic [1:0] pcm, a2, aluk;
        {ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc} = '0;
        {g_pc, g_mdr, g_alu, g_mm, a1, mio, flt} = '0;
        pcm = 2'b00; a2 = 2'b00; aluk = 2'b00;
        case (st)
            6'd18: begin g_pc = 1; ld_mar = 1; ld_pc = 1; end
            6'd33, 6'd25: begin mio = 1; ld_mdr = r; end
            6'd35: begin g_mdr = 1; ld_ir = 1; end
            6'd32: ld_ben = 1;
            6'd1:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; aluk = 2'b00; end
            6'd5:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; aluk = 2'b01; end
            6'd9:  begin g_alu = 1; ld_reg = 1; ld_cc = 1; aluk = 2'b10; end
            6'd22: begin ld_pc = 1; pcm = 2'b10; a2 = 2'b10; end
            6'd12: begin ld_pc = 1; pcm = 2'b10; a1 = 1; end
            6'd2:  begin g_mm = 1; ld_mar = 1; a2 = 2'b10; end
            6'd27: begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
            6'd62: flt = 1;
            default: ;
        endcase
        return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc,
                g_pc, g_mdr, g_alu, g_mm, pcm, a1, a2, aluk, mio, flt};
    endfunction

    task automatic add(input logic rst_n, input logic [15:0] ir,
                       input logic ben, input logic r, input logic [5:0] st);
        vec_t v;
        v.rst_n = rst_n; v.ir = ir; v.ben = ben; v.r = r; v.st = st;
        vecs.push_back(v);
    endtask

    // Fetch with a decoy illegal opcode on IR outside S32 to show it is ignored.
    task automatic fetch(input logic [15:0] ir, input int nwait, input logic ben32);
        add(1, 16'hD000, 0, 1, 6'd18);
        for (int i = 0; i < nwait; i++) add(1, 16'hD000, 0, 0, 6'd33);
        add(1, 16'hD000, 0, 1, 6'd33);
        add(1, 16'hD000, 0, 1, 6'd35);
        add(1, ir, ben32, 1, 6'd32);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        bit   found;

        // reset and first ADD (IR disturbed during execute)
        add(0, 16'h1042, 1, 0, 6'd63);
        add(0, 16'hFFFF, 0, 1, 6'd63);
        add(1, 16'h1042, 0, 1, 6'd63);
        fetch(16'h1042, 0, 0);
        add(1, 16'hD000, 1, 0, 6'd1);
        // AND with one fetch wait, NOT
        fetch(16'h5042, 1, 0);
        add(1, 16'hD000, 0, 1, 6'd5);
        fetch(16'h9042, 0, 0);
        add(1, 16'hD000, 0, 1, 6'd9);
        // BR taken, BEN dropped in S22 must not matter
        fetch(16'h0E05, 0, 0);
        add(1, 16'hD000, 1, 1, 6'd0);
        add(1, 16'hD000, 0, 1, 6'd22);
        // BR untaken, BEN high only at decode
        fetch(16'h0E05, 0, 1);
        add(1, 16'hD000, 0, 1, 6'd0);
        // JMP
        fetch(16'hC1C0, 0, 0);
        add(1, 16'hD000, 0, 1, 6'd12);
        // LD with three wait cycles, then with none
        fetch(16'h2203, 0, 0);
        add(1, 16'hD000, 0, 0, 6'd2);
        for (int i = 0; i < 3; i++) add(1, 16'hD000, 0, 0, 6'd25);
        add(1, 16'hD000, 0, 1, 6'd25);
        add(1, 16'hD000, 0, 1, 6'd27);
        fetch(16'h2203, 0, 0);
        add(1, 16'hD000, 0, 1, 6'd2);
        add(1, 16'hD000, 0, 1, 6'd25);
        add(1, 16'hD000, 0, 1, 6'd27);
`ifdef SEQ_MEM_WDT_EN
        // watchdog expiry, then R arriving on the expiry cycle
        add(1, 16'hD000, 0, 1, 6'd18);
        for (int i = 0; i < TIMEOUT; i++) add(1, 16'hD000, 0, 0, 6'd33);
        add(1, 16'h1042, 0, 1, 6'd62);
        add(0, 16'h1042, 0, 1, 6'd63);
        add(1, 16'h1042, 0, 1, 6'd63);
        fetch(16'h1042, TIMEOUT - 1, 0);
        add(1, 16'hD000, 0, 1, 6'd1);
`else
        // unbounded wait does not fault
        fetch(16'h1042, 20, 0);
        add(1, 16'hD000, 0, 1, 6'd1);
`endif
        // reset mid-wait aborts without a load
        add(1, 16'hD000, 0, 1, 6'd18);
        add(1, 16'hD000, 0, 0, 6'd33);
        add(1, 16'hD000, 0, 0, 6'd33);
        add(0, 16'hD000, 0, 1, 6'd63);
        add(0, 16'hD000, 0, 1, 6'd63);
        add(1, 16'hD000, 0, 1, 6'd63);
        // illegal opcode, sticky fault for 20 cycles, cleared by reset
        fetch(16'hD000, 0, 0);
        for (int i = 0; i < 20; i++)
            add(1, (i % 2 == 0) ? 16'h1042 : 16'h0000, 1'(i % 3 == 0), 1'(i % 2), 6'd62);
        add(0, 16'h1042, 0, 1, 6'd63);
        add(1, 16'h1042, 0, 1, 6'd63);
        fetch(16'h1042, 0, 0);
        add(1, 16'hD000, 0, 1, 6'd1);

        #1 RST_N = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            RST_N = vecs[i].rst_n;
            IR    = vecs[i].ir;
            BEN   = vecs[i].ben;
            R     = vecs[i].r;
            e.idx = i;
            e.st  = vecs[i].st;
            e.ctl = exp_ctl(vecs[i].st, vecs[i].r);
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            n_checks++;
            if ({STATE, act_ctl} !== {e.st, e.ctl}) begin
                n_fail++;
                $display("FAIL vec%0d: state/ctl got %0d/%05h, expected %0d/%05h",
                         e.idx, STATE, act_ctl, e.st, e.ctl);
            end
        end

        // Hand-written: last vector was ADD execute; next fetch reaches decode within a bound.
        R  = 1'b1;
        IR = 16'h5042;
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge CLK);
            #1;
            if (STATE == 6'd32) found = 1;
        end
        check("reach_decode", 32'(found), 32'd1);
        @(negedge CLK);
        IR = 16'h0000;
        #1;
        check("and_state", 32'(STATE), 32'd5);
        check("and_aluk", 32'(ALUK), 32'd1);
        check("and_ldcc", 32'(LD_CC), 32'd1);
        @(negedge CLK);
        #1;
        check("back_to_fetch", 32'(STATE), 32'd18);
        check("fetch_gate_pc", 32'({GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX}), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
